// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: load-use stalls, taken-branch flushes,
// debugger halt/drain FSM. Define HAZARD_STEP_EN to enable single-step from HALTED.
module pipeline_hazard_ctrl #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1_i,
    input  logic [4:0]       id_rs2_i,
    input  logic             id_uses_rs2_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rd_i,
    input  logic             mem_branch_taken_i,
    input  logic             halt_req_i,
    input  logic             step_req_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             exmem_flush_o,
    output logic             halted_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2,
        StStep   = 2'd3
    } state_e;

    state_e           state_q;
    logic [1:0]       drain_q;
    logic             halted_q;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic lu;
    logic issue_state;
    logic stall_ev;
    logic freeze;

`ifndef HAZARD_STEP_EN
    logic unused_step_req;
    assign unused_step_req = step_req_i;
`endif

    assign lu = idex_memread_i && (idex_rd_i != 5'd0) &&
                ((idex_rd_i == id_rs1_i) || (id_uses_rs2_i && (idex_rd_i == id_rs2_i)));

    assign issue_state = (state_q == StRun) || (state_q == StStep);
    // A taken branch squashes the load-use consumer, so no stall is charged.
    assign stall_ev    = lu && issue_state && !mem_branch_taken_i;
    assign freeze      = stall_ev || (state_q == StDrain) || (state_q == StHalted);

    always_comb begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        if (reset) begin
            pc_write_o = 1'b1;
        end else if (mem_branch_taken_i) begin
            ifid_flush_o  = 1'b1;
            idex_flush_o  = 1'b1;
            exmem_flush_o = 1'b1;
        end else if (freeze) begin
            pc_write_o   = 1'b0;
            ifid_write_o = 1'b0;
            idex_flush_o = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StRun;
            drain_q  <= 2'd0;
            halted_q <= 1'b0;
            stall_q  <= '0;
            flush_q  <= '0;
        end else begin
            if (stall_ev && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (mem_branch_taken_i && (flush_q != '1)) flush_q <= flush_q + 1'b1;
            halted_q <= 1'b0;
            unique case (state_q)
                StRun: begin
                    if (halt_req_i) begin
                        state_q <= StDrain;
                        drain_q <= 2'd3;
                    end
                end
                StDrain: begin
                    if (drain_q == 2'd1) begin
                        state_q  <= StHalted;
                        halted_q <= 1'b1;
                    end else begin
                        drain_q <= drain_q - 2'd1;
                    end
                end
                StHalted: begin
                    if (!halt_req_i) state_q <= StRun;
`ifdef HAZARD_STEP_EN
                    else if (step_req_i) state_q <= StStep;
`endif
                    else halted_q <= 1'b1;
                end
                StStep: begin
                    // Hold STEP until the stepped instruction actually issues.
                    if (!stall_ev) begin
                        state_q <= StDrain;
                        drain_q <= 2'd3;
                    end
                end
            endcase
        end
    end

    assign halted_o    = halted_q && !reset;
    assign state_o     = state_q;
    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: behavioural model compared every cycle, plus
// directed literal checks. A second instance with CNT_W=2 exercises counter saturation.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs1, id_rs2, idex_rd;
    logic       id_uses_rs2, idex_memread, br, halt_req, step_req;

    logic        pw, iw, ifl, idf, exf, halted;
    logic [1:0]  state;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_pw, s_iw, s_ifl, s_idf, s_exf, s_halted;
    logic [1:0]  s_state;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    pipeline_hazard_ctrl #(.CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_uses_rs2_i(id_uses_rs2), .idex_memread_i(idex_memread), .idex_rd_i(idex_rd),
        .mem_branch_taken_i(br), .halt_req_i(halt_req), .step_req_i(step_req),
        .pc_write_o(pw), .ifid_write_o(iw), .ifid_flush_o(ifl), .idex_flush_o(idf),
        .exmem_flush_o(exf), .halted_o(halted), .state_o(state),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(2)) u_dut_w2 (
        .clk(clk), .reset(reset), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
        .id_uses_rs2_i(id_uses_rs2), .idex_memread_i(idex_memread), .idex_rd_i(idex_rd),
        .mem_branch_taken_i(br), .halt_req_i(halt_req), .step_req_i(step_req),
        .pc_write_o(s_pw), .ifid_write_o(s_iw), .ifid_flush_o(s_ifl), .idex_flush_o(s_idf),
        .exmem_flush_o(s_exf), .halted_o(s_halted), .state_o(s_state),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: state numbers are the externally visible encoding; counts are unbounded ints.
    int  m_state = 0;
    int  m_drain = 0;
    int  m_stall = 0;
    int  m_flush = 0;
    bit  step_en;

    function automatic bit f_lu();
        return idex_memread && (idex_rd != 0) &&
               ((idex_rd == id_rs1) || (id_uses_rs2 && (idex_rd == id_rs2)));
    endfunction

    initial begin
`ifdef HAZARD_STEP_EN
        step_en = 1'b1;
`else
        step_en = 1'b0;
`endif
    end

    always @(posedge clk) begin
        bit stall;
        if (reset) begin
            m_state = 0; m_drain = 0; m_stall = 0; m_flush = 0;
        end else begin
            stall = f_lu() && !br && (m_state == 0 || m_state == 3);
            if (stall) m_stall++;
            if (br) m_flush++;
            case (m_state)
                0: if (halt_req) begin m_state = 1; m_drain = 3; end
                1: if (m_drain == 1) m_state = 2; else m_drain--;
                2: if (!halt_req) m_state = 0; else if (step_en && step_req) m_state = 3;
                default: if (!stall) begin m_state = 1; m_drain = 3; end
            endcase
        end
    end

    always @(negedge clk) begin
        bit e_pw, e_iw, e_ifl, e_idf, e_exf, e_halted, frz;
        if (chk_en) begin
            frz = (m_state == 1) || (m_state == 2) || ((m_state == 0 || m_state == 3) && f_lu());
            if (reset) begin
                e_pw = 1; e_iw = 1; e_ifl = 0; e_idf = 0; e_exf = 0; e_halted = 0;
            end else if (br) begin
                e_pw = 1; e_iw = 1; e_ifl = 1; e_idf = 1; e_exf = 1; e_halted = (m_state == 2);
            end else begin
                e_pw = !frz; e_iw = !frz; e_ifl = 0; e_idf = frz; e_exf = 0;
                e_halted = (m_state == 2);
            end
            check("m_pc_write", pw, e_pw);
            check("m_ifid_write", iw, e_iw);
            check("m_ifid_flush", ifl, e_ifl);
            check("m_idex_flush", idf, e_idf);
            check("m_exmem_flush", exf, e_exf);
            check("m_halted", halted, e_halted);
            check("m_state", state, m_state);
            check("m_stall_cnt", stall_cnt, (m_stall > 65535) ? 65535 : m_stall);
            check("m_flush_cnt", flush_cnt, (m_flush > 65535) ? 65535 : m_flush);
            check("m_w2_state", s_state, m_state);
            check("m_w2_pc_write", s_pw, e_pw);
            check("m_w2_stall_cnt", s_stall_cnt, (m_stall > 3) ? 3 : m_stall);
            check("m_w2_flush_cnt", s_flush_cnt, (m_flush > 3) ? 3 : m_flush);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        idex_memread = 0; idex_rd = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0; br = 0;
    endtask

    initial begin
        reset = 1; halt_req = 0; step_req = 0;
        clr();
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        chk_en = 1'b1;

        // load-use on rs1
        idex_memread = 1; idex_rd = 5; id_rs1 = 5;
        @(negedge clk);
        check("lu_rs1_pc_write", pw, 0);
        check("lu_rs1_ifid_write", iw, 0);
        check("lu_rs1_idex_flush", idf, 1);
        next(); clr();
        @(negedge clk);
        check("lu_rs1_stall_cnt", stall_cnt, 1);
        check("lu_rs1_resume", pw, 1);

        // rs2 match without rs2 use, and x0 destination: no stall
        next(); idex_memread = 1; idex_rd = 5; id_rs2 = 5; id_uses_rs2 = 0;
        @(negedge clk);
        check("no_rs2_use_pc_write", pw, 1);
        check("no_rs2_use_idex_flush", idf, 0);
        next(); idex_rd = 0; id_rs1 = 0;
        @(negedge clk);
        check("rd_x0_pc_write", pw, 1);
        next(); idex_rd = 5; id_rs2 = 5; id_uses_rs2 = 1;
        @(negedge clk);
        check("lu_rs2_pc_write", pw, 0);
        next(); clr();
        @(negedge clk);
        check("lu_rs2_stall_cnt", stall_cnt, 2);

        // taken branch overrides load-use
        next(); br = 1; idex_memread = 1; idex_rd = 7; id_rs1 = 7;
        @(negedge clk);
        check("br_pc_write", pw, 1);
        check("br_ifid_flush", ifl, 1);
        check("br_idex_flush", idf, 1);
        check("br_exmem_flush", exf, 1);
        next(); clr();
        @(negedge clk);
        check("br_flush_cnt", flush_cnt, 1);
        check("br_stall_cnt", stall_cnt, 2);

        // halt together with load-use, then drain and halt
        next(); halt_req = 1; idex_memread = 1; idex_rd = 3; id_rs1 = 3;
        @(negedge clk);
        check("halt_lu_pc_write", pw, 0);
        check("halt_lu_state", state, 0);
        next(); clr();
        @(negedge clk);
        check("drain1_state", state, 1);
        check("drain1_stall_cnt", stall_cnt, 3);
        check("drain1_pc_write", pw, 0);
        next(); @(negedge clk);
        check("drain2_state", state, 1);
        next(); @(negedge clk);
        check("drain3_state", state, 1);
        check("drain3_halted", halted, 0);
        next(); @(negedge clk);
        check("halted_state", state, 2);
        check("halted_flag", halted, 1);
        check("halted_pc_write", pw, 0);

`ifdef HAZARD_STEP_EN
        next(); step_req = 1;
        @(negedge clk);
        check("step_req_state", state, 2);
        next(); step_req = 0;
        @(negedge clk);
        check("step_state", state, 3);
        check("step_ifid_write", iw, 1);
        check("step_idex_flush", idf, 0);
        for (int i = 0; i < 3; i++) begin
            next(); @(negedge clk);
            check("step_drain_state", state, 1);
        end
        next(); @(negedge clk);
        check("step_halted", halted, 1);
`endif

        next(); halt_req = 0;
        @(negedge clk);
        check("resume_pre_state", state, 2);
        next(); @(negedge clk);
        check("resume_state", state, 0);
        check("resume_pc_write", pw, 1);
        check("resume_halted", halted, 0);

        // five stalls saturate the 2-bit counter
        next(); idex_memread = 1; idex_rd = 9; id_rs1 = 9;
        repeat (5) next();
        clr();
        @(negedge clk);
        check("sat_w2_stall_cnt", s_stall_cnt, 3);
        check("sat_stall_cnt", stall_cnt, 8);

        // reset clears counters, outputs forced while reset is high
        next(); reset = 1; idex_memread = 1; idex_rd = 4; id_rs1 = 4; br = 1;
        @(negedge clk);
        check("rst_pc_write", pw, 1);
        check("rst_exmem_flush", exf, 0);
        next(); reset = 0; clr();
        @(negedge clk);
        check("rst_stall_cnt", stall_cnt, 0);
        check("rst_flush_cnt", flush_cnt, 0);
        check("rst_w2_stall_cnt", s_stall_cnt, 0);

        // reset mid-drain
        next(); halt_req = 1;
        next(); @(negedge clk);
        check("mid_drain_state", state, 1);
        next(); reset = 1;
        @(negedge clk);
        check("mid_drain_rst_pc_write", pw, 1);
        check("mid_drain_rst_idex_flush", idf, 0);
        check("mid_drain_rst_halted", halted, 0);
        next(); reset = 0; halt_req = 0;
        @(negedge clk);
        check("mid_drain_after_state", state, 0);
        check("mid_drain_after_pc_write", pw, 1);

        repeat (3) next();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central hazard and sequencing controller for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB). It detects load-use hazards and inserts bubbles. It flushes younger stages when a branch resolves taken in MEM. It runs a halt/drain state machine so a debugger can freeze and inspect the core. Its outputs drive the PC write enable, the IF/ID write enable, and the IF/ID, ID/EX and EX/MEM flush inputs of the pipeline registers.

## Interface
- CNT_W, 16, width of the saturating event counters

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- id_rs1  in  5  source register 1 of the instruction in ID
- id_rs2  in  5  source register 2 of the instruction in ID
- id_uses_rs2  in  1  ID instruction reads rs2 (R-type, store, branch)
- idex_memread  in  1  EX-stage instruction is a load
- idex_rd  in  5  EX-stage destination register
- mem_branch_taken  in  1  MEM-stage branch resolved taken (branch && condition true)
- halt_req  in  1  debugger halt request (level)
- step_req  in  1  single-step pulse, only used when HAZARD_STEP_EN is defined
- pc_write  out  1  PC register load enable
- ifid_write  out  1  IF/ID register load enable
- ifid_flush  out  1  IF/ID clears to NOP
- idex_flush  out  1  ID/EX clears all control bits (bubble)
- exmem_flush  out  1  EX/MEM clears all control bits
- halted  out  1  core fully drained and frozen
- state  out  2  FSM state: RUN=0, DRAIN=1, HALTED=2, STEP=3
- stall_cnt  out  CNT_W  load-use stall cycles
- flush_cnt  out  CNT_W  taken-branch flush events

## Operation
- The hazard condition is combinational: lu = idex_memread && idex_rd!=0 && (idex_rd==id_rs1 || (id_uses_rs2 && idex_rd==id_rs2)).
- Freeze: pc_write=0, ifid_write=0, idex_flush=1.
- RUN: if lu, apply freeze. Otherwise pc_write=1, ifid_write=1, and all flushes are 0.
- Taken branch overrides everything in every state: pc_write=1, ifid_flush=1, idex_flush=1, exmem_flush=1, ifid_write=1. lu is ignored in that cycle.
- halt_req=1 sampled in RUN moves the FSM to DRAIN with the drain counter set to 3.
- DRAIN: apply freeze. The counter decrements each cycle. When the counter reaches 1, the FSM moves to HALTED. halt_req is ignored during DRAIN.
- HALTED: apply freeze and assert halted=1. halt_req=0 returns the FSM to RUN.
- STEP: one RUN-equivalent cycle, then DRAIN(3). If lu holds, the FSM stays in STEP, so the stall repeats until the instruction issues.
- stall_cnt increments in each cycle where lu causes the freeze in RUN or STEP. It does not increment when a taken branch overrides lu.
- flush_cnt increments in each cycle where mem_branch_taken=1.
- Both counters saturate at all-ones and are cleared only by reset.

## Timing
- All enable and flush outputs are combinational from the current state and inputs, valid in the same cycle.
- state, halted and the counters update on the posedge of clk.
- While reset=1: pc_write=1, ifid_write=1, all flushes=0, halted=0.
- On reset, state=RUN, counters=0, drain counter=0.
- Halt latency: halt_req is sampled at edge 0. DRAIN covers cycles 1-3, and halted=1 from cycle 4.
- Resume latency: halt_req=0 is sampled in HALTED, and the FSM is in RUN with pc_write=1 on the next cycle.
- Reset mid-DRAIN or mid-STEP: the FSM returns to RUN on that edge with no residual freeze.
- Simultaneous lu and halt_req in RUN: freeze this cycle, DRAIN next cycle.

## Configuration
- HAZARD_STEP_EN defined: in HALTED, step_req=1 with halt_req=1 moves the FSM to STEP. Exactly one instruction leaves IF/ID into EX, then the pipeline re-drains.
- HAZARD_STEP_EN undefined: step_req is ignored and the STEP state is unreachable. A state value of 3 must never appear.

## Test plan
- Load-use on rs1: idex_memread=1, idex_rd=5, id_rs1=5 -> pc_write=0, ifid_write=0, idex_flush=1 for 1 cycle; stall_cnt=1.
- Load-use on rs2 with no rs2 use: idex_rd=5, id_rs2=5, id_uses_rs2=0 -> no stall. Same case with idex_rd=0 and id_rs1=0 -> no stall.
- Taken branch coincident with lu: mem_branch_taken=1 and lu=1 -> pc_write=1, all three flushes=1; flush_cnt=1, stall_cnt unchanged.
- Halt/resume: halt_req at edge 0 -> state=1 in cycles 1-3, halted=1 at cycle 4. Drop halt_req -> state=0 and pc_write=1 one cycle later.
- Step (HAZARD_STEP_EN): in HALTED, pulse step_req -> one cycle with ifid_write=1 and idex_flush=0, then 3 DRAIN cycles, then halted=1.
- Counter saturation with CNT_W=2: five load-use stalls -> stall_cnt=3. Reset -> 0.
